// File: rtl/typed_slot_allocator_pkg.sv
// Shared types for the typed slot allocator: handle and override-entry layouts,
// response encodings and the response-register state enum.
package typed_alloc_pkg;

  localparam int N_TYPES_DEF = 4;
  localparam int SLOTS_DEF   = 8;
  localparam int TYPE_W_DEF  = $clog2(N_TYPES_DEF);
  localparam int SLOT_W_DEF  = $clog2(SLOTS_DEF);

  typedef struct packed {
    logic [TYPE_W_DEF-1:0] typ;
    logic [SLOT_W_DEF-1:0] slot;
  } handle_t;

  typedef struct packed {
    logic                  en;
    logic [TYPE_W_DEF-1:0] dst;
  } ovr_entry_t;

  localparam logic RESP_FULL = 1'b0;
  localparam logic RESP_OK   = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } resp_state_t;

endpackage

// File: rtl/find_first_zero.sv
// Combinational lowest-index zero finder; none_o flags an all-ones input.
module find_first_zero #(
  parameter int W     = 8,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     bits_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             none_o
);

  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      if (!bits_i[i]) begin
        idx_o  = IDX_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/typed_slot_allocator.sv
// Per-type slot pools with a one-level override table and a single-entry
// response register. Handle and override widths follow the package defaults.
module typed_slot_allocator
  import typed_alloc_pkg::*;
#(
  parameter int N_TYPES = N_TYPES_DEF,
  parameter int SLOTS   = SLOTS_DEF,
  parameter int TYPE_W  = $clog2(N_TYPES),
  parameter int SLOT_W  = $clog2(SLOTS),
  parameter int CNT_W   = $clog2(SLOTS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [TYPE_W-1:0]         alloc_type,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_ok,
  output logic [TYPE_W+SLOT_W-1:0]  resp_handle,
  input  logic                      free_valid,
  input  logic [TYPE_W+SLOT_W-1:0]  free_handle,
  output logic                      free_err,
  input  logic                      ovr_we,
  input  logic [TYPE_W-1:0]         ovr_src,
  input  logic [TYPE_W-1:0]         ovr_dst,
  output logic [N_TYPES*CNT_W-1:0]  occupancy
);

  resp_state_t                     state_q, state_d;
  logic [N_TYPES-1:0][SLOTS-1:0]   busy_q, busy_d;
  logic [N_TYPES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  ovr_entry_t [N_TYPES-1:0]        ovr_q, ovr_d;
  logic                            resp_ok_q, resp_ok_d;
  handle_t                         resp_h_q, resp_h_d;
  logic                            free_err_q, free_err_d;

  logic              accept, type_ok, none, grant;
  logic [TYPE_W-1:0] resolved;
  logic [SLOTS-1:0]  pool_map;
  logic [SLOT_W-1:0] slot;
  handle_t           free_h;
  logic              free_ok, free_hit;

  assign alloc_ready = (state_q == ST_EMPTY) || resp_ready;
  assign accept      = alloc_valid && alloc_ready;
  assign type_ok     = 32'(alloc_type) < N_TYPES;
  assign resolved    = (type_ok && ovr_q[alloc_type].en) ? ovr_q[alloc_type].dst : alloc_type;
  // Allocation looks at the pre-free bitmap, so a slot freed this cycle is never re-granted.
  assign pool_map    = type_ok ? busy_q[resolved] : '1;
  assign grant       = accept && type_ok && !none;

  find_first_zero #(.W(SLOTS), .IDX_W(SLOT_W)) u_ffz (
    .bits_i (pool_map),
    .idx_o  (slot),
    .none_o (none)
  );

  assign free_h   = handle_t'(free_handle);
  assign free_ok  = (32'(free_h.typ) < N_TYPES) && (32'(free_h.slot) < SLOTS);
  assign free_hit = free_valid && free_ok && busy_q[free_h.typ][free_h.slot];

  always_comb begin
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    ovr_d      = ovr_q;
    state_d    = state_q;
    resp_ok_d  = resp_ok_q;
    resp_h_d   = resp_h_q;
    free_err_d = free_valid && !free_hit;

    if (free_hit) busy_d[free_h.typ][free_h.slot] = 1'b0;
    if (grant)    busy_d[resolved][slot] = 1'b1;

    for (int t = 0; t < N_TYPES; t++) begin
      if (grant && resolved == TYPE_W'(t))       cnt_d[t] = cnt_d[t] + CNT_W'(1);
      if (free_hit && free_h.typ == TYPE_W'(t))  cnt_d[t] = cnt_d[t] - CNT_W'(1);
    end

    if (ovr_we && (32'(ovr_src) < N_TYPES) && (32'(ovr_dst) < N_TYPES)) begin
      ovr_d[ovr_src].en  = (ovr_src != ovr_dst);
      ovr_d[ovr_src].dst = ovr_dst;
    end

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && resp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (accept) begin
      resp_ok_d = grant ? RESP_OK : RESP_FULL;
      resp_h_d  = '0;
      if (type_ok) begin
        resp_h_d.typ = resolved;
        if (grant) resp_h_d.slot = slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      busy_q     <= '0;
      cnt_q      <= '0;
      ovr_q      <= '0;
      resp_ok_q  <= 1'b0;
      resp_h_q   <= '0;
      free_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
      resp_ok_q  <= resp_ok_d;
      resp_h_q   <= resp_h_d;
      free_err_q <= free_err_d;
    end
  end

  assign resp_valid  = (state_q == ST_FULL);
  assign resp_ok     = resp_ok_q;
  assign resp_handle = resp_h_q;
  assign free_err    = free_err_q;
  assign occupancy   = cnt_q;

endmodule

// File: tb/tb_typed_slot_allocator.sv
// Scoreboard bench: directed scenarios plus random traffic against an array-based pool model.
module tb_typed_slot_allocator;

  localparam int NT = 4;
  localparam int NS = 8;
  localparam int TW = 2;
  localparam int SW = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alloc_valid = 1'b0;
  logic alloc_ready;
  logic [TW-1:0] alloc_type = '0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic resp_ok;
  logic [TW+SW-1:0] resp_handle;
  logic free_valid = 1'b0;
  logic [TW+SW-1:0] free_handle = '0;
  logic free_err;
  logic ovr_we = 1'b0;
  logic [TW-1:0] ovr_src = '0;
  logic [TW-1:0] ovr_dst = '0;
  logic [NT*CW-1:0] occupancy;

  always #5 clk = ~clk;

  typed_slot_allocator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_type  (alloc_type),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_ok     (resp_ok),
    .resp_handle (resp_handle),
    .free_valid  (free_valid),
    .free_handle (free_handle),
    .free_err    (free_err),
    .ovr_we      (ovr_we),
    .ovr_src     (ovr_src),
    .ovr_dst     (ovr_dst),
    .occupancy   (occupancy)
  );

  typedef struct {
    bit ok;
    int handle;
  } exp_t;

  exp_t sb[$];
  bit   mbusy[NT][NS];
  bit   men[NT];
  int   mdst[NT];
  bit   mpend;
  bit   merr;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int used(input int t);
    int n = 0;
    for (int s = 0; s < NS; s++) n += int'(mbusy[t][s]);
    return n;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      men[t] = 1'b0;
      mdst[t] = 0;
      for (int s = 0; s < NS; s++) mbusy[t][s] = 1'b0;
    end
    mpend = 1'b0;
    merr = 1'b0;
    sb.delete();
  endtask

  // Applies the effect of the coming rising edge to the model, given the current inputs.
  task automatic model_step();
    bit acc;
    int r, slot, ft, fs;
    acc = alloc_valid && (!mpend || resp_ready);
    slot = -1;
    r = 0;
    if (acc) begin
      r = men[int'(alloc_type)] ? mdst[int'(alloc_type)] : int'(alloc_type);
      for (int s = 0; s < NS; s++) begin
        if (!mbusy[r][s]) begin
          slot = s;
          break;
        end
      end
      if (slot >= 0) sb.push_back('{1'b1, r * NS + slot});
      else           sb.push_back('{1'b0, r * NS});
    end
    merr = 1'b0;
    if (free_valid) begin
      ft = int'(free_handle) / NS;
      fs = int'(free_handle) % NS;
      if (mbusy[ft][fs]) mbusy[ft][fs] = 1'b0;
      else               merr = 1'b1;
    end
    if (acc && slot >= 0) mbusy[r][slot] = 1'b1;
    if (ovr_we) begin
      men[int'(ovr_src)]  = (ovr_src != ovr_dst);
      mdst[int'(ovr_src)] = int'(ovr_dst);
    end
    if (acc)             mpend = 1'b1;
    else if (resp_ready) mpend = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    chk("resp_valid", int'(resp_valid), int'(mpend));
    chk("alloc_ready", int'(alloc_ready), int'(!mpend || resp_ready));
    chk("free_err", int'(free_err), int'(merr));
    for (int t = 0; t < NT; t++)
      chk($sformatf("occupancy%0d", t), int'(occupancy[t*CW +: CW]), used(t));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit av, input int at, input bit rr,
                      input bit fv = 1'b0, input int fh = 0,
                      input bit ow = 1'b0, input int os = 0, input int od = 0);
    alloc_valid = av;
    alloc_type  = TW'(at);
    resp_ready  = rr;
    free_valid  = fv;
    free_handle = (TW+SW)'(fh);
    ovr_we      = ow;
    ovr_src     = TW'(os);
    ovr_dst     = TW'(od);
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected: got handle %0d with no expected response", resp_handle);
      end else begin
        chk("resp_ok", int'(resp_ok), int'(sb[0].ok));
        chk("resp_handle", int'(resp_handle), sb[0].handle);
        if (resp_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_ok", int'(resp_ok), 0);
    chk("rst_resp_handle", int'(resp_handle), 0);
    chk("rst_free_err", int'(free_err), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) step(1'b1, 2, 1'b1);
    step(1'b0, 0, 1'b1);
    chk("occ2_full", int'(occupancy[2*CW +: CW]), 8);

    step(1'b0, 0, 1'b1, 1'b1, 2*NS + 3);
    step(1'b1, 2, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1, 2*NS + 3);
    step(1'b0, 0, 1'b1, 1'b1, 2*NS + 3);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    chk("occ2_after_double_free", int'(occupancy[2*CW +: CW]), 7);

    step(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1, 3);
    step(1'b1, 1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1, 1);
    step(1'b1, 1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 0, 1);
    step(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1, 3);
    step(1'b1, 0, 1'b1);
    step(1'b0, 0, 1'b1);

    step(1'b1, 3, 1'b1);
    repeat (5) step(1'b1, 3, 1'b0);
    step(1'b1, 3, 1'b1);
    step(1'b0, 0, 1'b1);

    step(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 0, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b1);
    step(1'b1, 0, 1'b1, 1'b1, 5);
    step(1'b1, 0, 1'b1);
    step(1'b0, 0, 1'b1);

    repeat (400) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 31)),
           $urandom_range(0, 15) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);

    step(1'b1, 1, 1'b0);
    chk("pre_reset_valid", int'(resp_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_resp_valid", int'(resp_valid), 0);
    chk("async_rst_resp_ok", int'(resp_ok), 0);
    chk("async_rst_resp_handle", int'(resp_handle), 0);
    chk("async_rst_free_err", int'(free_err), 0);
    chk("async_rst_occupancy", int'(occupancy), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
